mac_seq: RTL and testbench
==========================

# mac_seq

Job-level sequencer for the shared vector MAC datapath. It accepts a job command (mode, beat count, initial bias), streams operand beats into the MAC, and feeds each MAC result back as the next partial sum. When the job finishes it presents the final 24-bit accumulation on a result handshake. It sits between the tile operand buffers / scheduler and one MAC instance, and it owns the MAC's mode, psum and operand ports.

## Interface
Parameters:
- LEN_W, 8, width of job beat count; max job length 2^LEN_W-1 beats

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high
- i_cmd_valid  in  1  job command valid
- o_cmd_ready  out  1  high only in IDLE
- i_cmd_mode  in  2  0 INT8, 1 INT4, 2 INT4_VSQ, 3 illegal
- i_cmd_len  in  LEN_W  number of operand beats
- i_cmd_bias  in  24  initial psum (signed)
- i_op_valid  in  1  operand beat valid
- o_op_ready  out  1  high only in RUN
- i_op_a, i_op_b  in  256  flattened operand vectors
- i_op_scale_a, i_op_scale_b  in  8  VSQ scale factors for this beat
- o_mac_mode  out  2  to MAC i_mode
- o_mac_psum  out  24  to MAC i_psum
- o_mac_a, o_mac_b  out  256  to MAC i_a / i_b
- o_mac_scale_a, o_mac_scale_b  out  8  to MAC scales
- i_mac_result  in  24  from MAC o_result (combinational)
- o_res_valid  out  1  result valid
- i_res_ready  in  1  result consumer ready
- o_res_data  out  24  final accumulation
- o_res_err  out  1  job used illegal mode; qualified by o_res_valid

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: o_cmd_ready=1. On cmd handshake, latch mode_r, len_r, acc<=i_cmd_bias, cnt<=0, err_r<=(mode==3).
  - If i_cmd_mode==3 or i_cmd_len==0, go to DONE. Otherwise go to RUN.
- RUN: o_op_ready=1.
  - o_mac_a/b/scale_a/scale_b = the i_op_* values while i_op_valid=1, else 0 (operand gating).
  - o_mac_psum=acc. o_mac_mode=mode_r in all states.
  - On op handshake: acc<=i_mac_result, cnt<=cnt+1. If cnt==len_r-1, go to DONE.
  - No beat is accepted outside RUN.
- DONE: o_res_valid=1, o_res_data=acc, o_res_err=err_r. All four signals hold stable until i_res_ready=1. On result handshake, go to IDLE.
- In IDLE and DONE, o_mac_psum=0 and the MAC operand outputs are 0.
- Arithmetic: acc takes i_mac_result verbatim. Wrap (INT8/INT4) and saturation (VSQ) are the MAC's responsibility; the sequencer does no extension or clipping.
- cnt is LEN_W bits and never wraps, because len_r ≤ 2^LEN_W-1.
- No command is queued. A new cmd is accepted only in IDLE, so back-to-back jobs always pass through IDLE for one cycle.

## Timing
- Reset (i_rst=1 at a clock edge), any state: next state IDLE; acc=0, cnt=0, mode_r=0, err_r=0.
  - Outputs after reset: o_cmd_ready=1, o_op_ready=0, o_res_valid=0, o_res_data=0, o_res_err=0, o_mac_mode=0, o_mac_psum=0, MAC operands 0.
  - Reset in the middle of RUN or DONE abandons the job. No result is emitted for it.
- cmd handshake at cycle T → RUN (o_op_ready=1) from T+1.
- Beats accepted with no bubbles: last beat at T+N → o_res_valid=1 at T+N+1.
- Minimum job cost is N+2 cycles with i_res_ready held high (cmd, N beats, DONE).
- len=0 or illegal mode: cmd at T → o_res_valid at T+1 with o_res_data=bias.
- i_op_valid gaps stall RUN indefinitely. acc and cnt hold during a stall.
- o_res_valid does not depend combinationally on i_res_ready. o_cmd_ready and o_op_ready are decoded from state only.

## Configuration
- MAC_SEQ_STALL_CNT_EN defined:
  - Adds output o_stall_cnt [15:0].
  - The counter clears on cmd handshake, increments each RUN cycle with i_op_valid=0, and saturates at 16'hFFFF.
  - It holds its value through DONE and IDLE until the next cmd. Reset value 0.
- MAC_SEQ_STALL_CNT_EN undefined: the port and the counter are absent; all other behaviour is identical.

## Test plan
The bench pairs the block with a real MAC instance.
- INT8, len=2, bias=10, a=all bytes 1, b=all bytes 2, no stalls, i_res_ready=1 → o_res_data=138 at cmd+3; o_res_err=0.
- INT4, len=3, bias=−5, a=all nibbles 1, b=all nibbles 1, one-cycle i_op_valid gap before beat 2 → o_res_data=187 one cycle later than the no-stall case. With MAC_SEQ_STALL_CNT_EN, o_stall_cnt=1.
- len=0, bias=0x00ABCD, any mode; and separately mode=3, len=5, bias=7 → result at cmd+1 equal to the bias. o_res_err=0 for the first case and 1 for the second. No op beats are accepted in either case.
- Result backpressure: hold i_res_ready=0 for 4 cycles in DONE → o_res_valid, o_res_data and o_res_err stable. o_cmd_ready=0 and o_op_ready=0 throughout. IDLE one cycle after ready rises.
- Reset mid-RUN after beat 1 of 4 (INT8) → next cycle IDLE with all outputs at reset values. A following job with len=1, bias=0, a=b=all 1 yields 32, with no residue from the aborted job.

Source files
------------

// File: rtl/mac_seq.sv
`default_nettype none
// ============================================================================
// Module      : mac_seq
// Description : Job-level sequencer for the shared vector MAC datapath.
//               It accepts a job command (mode, beat count, bias) and streams
//               operand beats into one MAC. Each MAC result is fed back as
//               the next partial sum, and the final 24-bit accumulation is
//               returned on a result handshake.
//               Optional build macro MAC_SEQ_STALL_CNT_EN adds o_stall_cnt,
//               a saturating count of RUN cycles spent waiting for operands.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_seq #(
    parameter int LEN_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    // Job command
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [1:0]       i_cmd_mode,
    input  logic [LEN_W-1:0] i_cmd_len,
    input  logic [23:0]      i_cmd_bias,
    // Operand beats
    input  logic             i_op_valid,
    output logic             o_op_ready,
    input  logic [255:0]     i_op_a,
    input  logic [255:0]     i_op_b,
    input  logic [7:0]       i_op_scale_a,
    input  logic [7:0]       i_op_scale_b,
    // MAC datapath
    output logic [1:0]       o_mac_mode,
    output logic [23:0]      o_mac_psum,
    output logic [255:0]     o_mac_a,
    output logic [255:0]     o_mac_b,
    output logic [7:0]       o_mac_scale_a,
    output logic [7:0]       o_mac_scale_b,
    input  logic [23:0]      i_mac_result,
    // Job result
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [23:0]      o_res_data,
    output logic             o_res_err
`ifdef MAC_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]      o_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0]       c_MODE_ILLEGAL = 2'd3;
    localparam logic [LEN_W-1:0] c_LEN_ZERO     = '0;
    localparam logic [LEN_W-1:0] c_LEN_ONE      = LEN_W'(1);

    state_t           r_state_q, w_state_d;
    logic [23:0]      r_acc_q,   w_acc_d;
    logic [LEN_W-1:0] r_cnt_q,   w_cnt_d;
    logic [LEN_W-1:0] r_len_q,   w_len_d;
    logic [1:0]       r_mode_q,  w_mode_d;
    logic             r_err_q,   w_err_d;

    logic w_in_idle;
    logic w_in_run;
    logic w_in_done;
    logic w_cmd_fire;
    logic w_op_fire;
    logic w_res_fire;
    logic w_last_beat;
    logic w_gate;

    assign w_in_idle   = (r_state_q == ST_IDLE);
    assign w_in_run    = (r_state_q == ST_RUN);
    assign w_in_done   = (r_state_q == ST_DONE);
    assign w_cmd_fire  = w_in_idle & i_cmd_valid;
    assign w_op_fire   = w_in_run  & i_op_valid;
    assign w_res_fire  = w_in_done & i_res_ready;
    // len_r is never zero in RUN, so len_r-1 cannot underflow here
    assign w_last_beat = (r_cnt_q == (r_len_q - c_LEN_ONE));
    // Operands reach the MAC only for a live beat; otherwise the MAC sees 0
    assign w_gate      = w_in_run & i_op_valid;

    // Handshakes and status are decoded from state only
    assign o_cmd_ready   = w_in_idle;
    assign o_op_ready    = w_in_run;
    assign o_res_valid   = w_in_done;
    assign o_res_data    = w_in_done ? r_acc_q : 24'd0;
    assign o_res_err     = w_in_done & r_err_q;

    assign o_mac_mode    = r_mode_q;
    assign o_mac_psum    = w_in_run ? r_acc_q : 24'd0;
    assign o_mac_a       = w_gate ? i_op_a       : 256'd0;
    assign o_mac_b       = w_gate ? i_op_b       : 256'd0;
    assign o_mac_scale_a = w_gate ? i_op_scale_a : 8'd0;
    assign o_mac_scale_b = w_gate ? i_op_scale_b : 8'd0;

    // Next-state, accumulator and job-context computation
    always_comb begin
        w_state_d = r_state_q;
        w_acc_d   = r_acc_q;
        w_cnt_d   = r_cnt_q;
        w_len_d   = r_len_q;
        w_mode_d  = r_mode_q;
        w_err_d   = r_err_q;
        unique case (r_state_q)
            ST_IDLE: begin
                if (w_cmd_fire) begin
                    w_mode_d = i_cmd_mode;
                    w_len_d  = i_cmd_len;
                    w_acc_d  = i_cmd_bias;
                    w_cnt_d  = c_LEN_ZERO;
                    w_err_d  = (i_cmd_mode == c_MODE_ILLEGAL);
                    // Illegal or empty jobs skip straight to the result
                    if ((i_cmd_mode == c_MODE_ILLEGAL) || (i_cmd_len == c_LEN_ZERO)) begin
                        w_state_d = ST_DONE;
                    end else begin
                        w_state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (w_op_fire) begin
                    // MAC output is taken verbatim; wrap/saturation live in the MAC
                    w_acc_d = i_mac_result;
                    w_cnt_d = r_cnt_q + c_LEN_ONE;
                    if (w_last_beat) begin
                        w_state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (w_res_fire) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers; reset abandons any job in flight
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q <= ST_IDLE;
            r_acc_q   <= 24'd0;
            r_cnt_q   <= c_LEN_ZERO;
            r_len_q   <= c_LEN_ZERO;
            r_mode_q  <= 2'd0;
            r_err_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_acc_q   <= w_acc_d;
            r_cnt_q   <= w_cnt_d;
            r_len_q   <= w_len_d;
            r_mode_q  <= w_mode_d;
            r_err_q   <= w_err_d;
        end
    end

`ifdef MAC_SEQ_STALL_CNT_EN
    logic [15:0] r_stall_q, w_stall_d;

    // Count RUN cycles starved of operands; cleared per job, saturating
    always_comb begin
        w_stall_d = r_stall_q;
        if (w_cmd_fire) begin
            w_stall_d = 16'd0;
        end else if (w_in_run && !i_op_valid && (r_stall_q != 16'hFFFF)) begin
            w_stall_d = r_stall_q + 16'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_q <= 16'd0;
        end else begin
            r_stall_q <= w_stall_d;
        end
    end

    assign o_stall_cnt = r_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mac_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_seq
// Description : Directed self-checking bench for mac_seq, paired with a
//               behavioural vector MAC (INT8 / INT4 / INT4_VSQ).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_seq;

    localparam int LEN_W = 8;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_mode;
    logic [LEN_W-1:0] cmd_len;
    logic [23:0]      cmd_bias;
    logic             op_valid;
    logic             op_ready;
    logic [255:0]     op_a;
    logic [255:0]     op_b;
    logic [7:0]       op_sa;
    logic [7:0]       op_sb;
    logic [1:0]       mac_mode;
    logic [23:0]      mac_psum;
    logic [255:0]     mac_a;
    logic [255:0]     mac_b;
    logic [7:0]       mac_sa;
    logic [7:0]       mac_sb;
    logic [23:0]      mac_res;
    logic             res_valid;
    logic             res_ready;
    logic [23:0]      res_data;
    logic             res_err;
`ifdef MAC_SEQ_STALL_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    mac_seq #(.LEN_W(LEN_W)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_mode    (cmd_mode),
        .i_cmd_len     (cmd_len),
        .i_cmd_bias    (cmd_bias),
        .i_op_valid    (op_valid),
        .o_op_ready    (op_ready),
        .i_op_a        (op_a),
        .i_op_b        (op_b),
        .i_op_scale_a  (op_sa),
        .i_op_scale_b  (op_sb),
        .o_mac_mode    (mac_mode),
        .o_mac_psum    (mac_psum),
        .o_mac_a       (mac_a),
        .o_mac_b       (mac_b),
        .o_mac_scale_a (mac_sa),
        .o_mac_scale_b (mac_sb),
        .i_mac_result  (mac_res),
        .o_res_valid   (res_valid),
        .i_res_ready   (res_ready),
        .o_res_data    (res_data),
        .o_res_err     (res_err)
`ifdef MAC_SEQ_STALL_CNT_EN
        ,
        .o_stall_cnt   (stall_cnt)
`endif
    );

    // Behavioural MAC: dot product of signed lanes plus psum
    function automatic logic [23:0] mac_f(input logic [1:0] m, input logic [23:0] p,
                                          input logic [255:0] a, input logic [255:0] b,
                                          input logic [7:0] sa, input logic [7:0] sb);
        longint acc;
        longint dot;
        acc = longint'($signed(p));
        dot = 0;
        case (m)
            2'd0: begin
                for (int i = 0; i < 32; i++)
                    dot += longint'($signed(a[i*8 +: 8])) * longint'($signed(b[i*8 +: 8]));
                acc += dot;
            end
            2'd1, 2'd2: begin
                for (int i = 0; i < 64; i++)
                    dot += longint'($signed(a[i*4 +: 4])) * longint'($signed(b[i*4 +: 4]));
                if (m == 2'd2) begin
                    acc += dot * longint'(sa) * longint'(sb);
                    if (acc > 64'sd8388607)  acc = 64'sd8388607;
                    if (acc < -64'sd8388608) acc = -64'sd8388608;
                end else begin
                    acc += dot;
                end
            end
            default: acc = acc;
        endcase
        return acc[23:0];
    endfunction

    assign mac_res = mac_f(mac_mode, mac_psum, mac_a, mac_b, mac_sa, mac_sb);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 256'(cmd_ready), 256'd1);
        chk({tag, "_op_ready"},  256'(op_ready),  256'd0);
        chk({tag, "_res_valid"}, 256'(res_valid), 256'd0);
        chk({tag, "_res_data"},  256'(res_data),  256'd0);
        chk({tag, "_res_err"},   256'(res_err),   256'd0);
        chk({tag, "_mac_mode"},  256'(mac_mode),  256'd0);
        chk({tag, "_mac_psum"},  256'(mac_psum),  256'd0);
        chk({tag, "_mac_a"},     mac_a,           256'd0);
        chk({tag, "_mac_b"},     mac_b,           256'd0);
`ifdef MAC_SEQ_STALL_CNT_EN
        chk({tag, "_stall"},     256'(stall_cnt), 256'd0);
`endif
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_mode  = 2'd0;
        cmd_len   = '0;
        cmd_bias  = 24'd0;
        op_valid  = 1'b0;
        op_a      = 256'd0;
        op_b      = 256'd0;
        op_sa     = 8'd0;
        op_sb     = 8'd0;
        res_ready = 1'b1;

        step();
        step();
        chk_reset_outputs("rst");
        rst = 1'b0;

        // Job 1: INT8, len=2, bias=10, a=1s, b=2s -> 10 + 2*64 = 138
        cmd_valid = 1'b1; cmd_mode = 2'd0; cmd_len = 8'd2; cmd_bias = 24'd10;
        step();
        cmd_valid = 1'b0;
        op_valid = 1'b1; op_a = {32{8'h01}}; op_b = {32{8'h02}};
        #1;
        chk("j1_op_ready", 256'(op_ready), 256'd1);
        chk("j1_cmd_ready", 256'(cmd_ready), 256'd0);
        chk("j1_psum0", 256'(mac_psum), 256'd10);
        chk("j1_mac_a", mac_a, {32{8'h01}});
        step();
        chk("j1_psum1", 256'(mac_psum), 256'd74);
        step();
        op_valid = 1'b0;
        #1;
        chk("j1_valid", 256'(res_valid), 256'd1);
        chk("j1_data", 256'(res_data), 256'd138);
        chk("j1_err", 256'(res_err), 256'd0);
        chk("j1_done_psum", 256'(mac_psum), 256'd0);
        step();
        chk("j1_idle", 256'(cmd_ready), 256'd1);
        chk("j1_valid_low", 256'(res_valid), 256'd0);

        // Job 2: INT4, len=3, bias=-5, nibbles 1, one gap -> -5 + 3*64 = 187
        cmd_valid = 1'b1; cmd_mode = 2'd1; cmd_len = 8'd3; cmd_bias = 24'hFFFFFB;
        step();
        cmd_valid = 1'b0;
        op_valid = 1'b1; op_a = {64{4'h1}}; op_b = {64{4'h1}};
        step();
        op_valid = 1'b0;
        #1;
        chk("j2_gap_op_ready", 256'(op_ready), 256'd1);
        chk("j2_gap_mac_a", mac_a, 256'd0);
        chk("j2_gap_psum", 256'(mac_psum), 256'd59);
        step();
        op_valid = 1'b1;
        step();
        chk("j2_not_yet", 256'(res_valid), 256'd0);
        step();
        op_valid = 1'b0;
        #1;
        chk("j2_valid", 256'(res_valid), 256'd1);
        chk("j2_data", 256'(res_data), 256'd187);
        chk("j2_err", 256'(res_err), 256'd0);
`ifdef MAC_SEQ_STALL_CNT_EN
        chk("j2_stall", 256'(stall_cnt), 256'd1);
`endif
        step();

        // Job 3a: len=0, bias=0xABCD, beats offered but must not be taken
        cmd_valid = 1'b1; cmd_mode = 2'd2; cmd_len = 8'd0; cmd_bias = 24'h00ABCD;
        op_valid = 1'b1; op_a = {32{8'h01}}; op_b = {32{8'h01}};
        step();
        cmd_valid = 1'b0;
        #1;
        chk("j3a_valid", 256'(res_valid), 256'd1);
        chk("j3a_data", 256'(res_data), 256'h00ABCD);
        chk("j3a_err", 256'(res_err), 256'd0);
        chk("j3a_op_ready", 256'(op_ready), 256'd0);
        chk("j3a_mac_a", mac_a, 256'd0);
        step();
        op_valid = 1'b0;
        chk("j3a_idle", 256'(cmd_ready), 256'd1);

        // Job 3b: illegal mode, len=5, bias=7 -> result 7 with error flag
        cmd_valid = 1'b1; cmd_mode = 2'd3; cmd_len = 8'd5; cmd_bias = 24'd7;
        step();
        cmd_valid = 1'b0;
        chk("j3b_valid", 256'(res_valid), 256'd1);
        chk("j3b_data", 256'(res_data), 256'd7);
        chk("j3b_err", 256'(res_err), 256'd1);
        chk("j3b_op_ready", 256'(op_ready), 256'd0);
        chk("j3b_mac_mode", 256'(mac_mode), 256'd3);
        step();
        chk("j3b_idle", 256'(cmd_ready), 256'd1);

        // Job 4: backpressure, INT8 len=1 bias=1 a=1s b=3s -> 1 + 96 = 97
        res_ready = 1'b0;
        cmd_valid = 1'b1; cmd_mode = 2'd0; cmd_len = 8'd1; cmd_bias = 24'd1;
        step();
        cmd_valid = 1'b0;
        op_valid = 1'b1; op_a = {32{8'h01}}; op_b = {32{8'h03}};
        step();
        op_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("j4_valid", 256'(res_valid), 256'd1);
            chk("j4_data", 256'(res_data), 256'd97);
            chk("j4_err", 256'(res_err), 256'd0);
            chk("j4_cmd_ready", 256'(cmd_ready), 256'd0);
            chk("j4_op_ready", 256'(op_ready), 256'd0);
            step();
        end
        res_ready = 1'b1;
        step();
        chk("j4_idle", 256'(cmd_ready), 256'd1);
        chk("j4_valid_low", 256'(res_valid), 256'd0);

        // Job 5: reset after beat 1 of 4, then a clean len=1 job -> 32
        cmd_valid = 1'b1; cmd_mode = 2'd0; cmd_len = 8'd4; cmd_bias = 24'd100;
        step();
        cmd_valid = 1'b0;
        op_valid = 1'b1; op_a = {32{8'h01}}; op_b = {32{8'h01}};
        step();
        chk("j5_psum_mid", 256'(mac_psum), 256'd132);
        op_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_outputs("j5_rst");
        cmd_valid = 1'b1; cmd_mode = 2'd0; cmd_len = 8'd1; cmd_bias = 24'd0;
        step();
        cmd_valid = 1'b0;
        op_valid = 1'b1;
        #1;
        chk("j5_psum_clean", 256'(mac_psum), 256'd0);
        step();
        op_valid = 1'b0;
        chk("j5_valid", 256'(res_valid), 256'd1);
        chk("j5_data", 256'(res_data), 256'd32);
        chk("j5_err", 256'(res_err), 256'd0);
        step();
        chk("j5_idle", 256'(cmd_ready), 256'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
